// File: rtl/exc_unit_if.sv
// rtl/exc_unit_if.sv - exception unit bus: check-point instruction inputs, redirect/status outputs
interface exc_unit_if #(
  parameter int XLEN = 32
);
  logic            instr_valid;
  logic [XLEN-1:0] instr_pc;
  logic            excp;
  logic            ovf;
  logic            eret;
  logic            irq;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic [XLEN-1:0] epc;
  logic [4:0]      cause;
  logic            in_handler;
  logic            dbl_fault;

  // Pipeline control side: presents the instruction, consumes the redirect
  modport master (
    output instr_valid, instr_pc, excp, ovf, eret, irq,
    input  redirect, redirect_pc, flush, epc, cause, in_handler, dbl_fault
  );

  // Exception unit side
  modport slave (
    input  instr_valid, instr_pc, excp, ovf, eret, irq,
    output redirect, redirect_pc, flush, epc, cause, in_handler, dbl_fault
  );
endinterface

// File: rtl/exc_unit.sv
// rtl/exc_unit.sv - trap/exception sequencer; EXC_IRQ_EN enables the synchronised irq source
module exc_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] HANDLER_VEC = 32'h0000_0180
) (
  input  logic       clk,
  input  logic       reset,
  exc_unit_if.slave  exc
);

  localparam logic [4:0] CAUSE_INT = 5'd0;
  localparam logic [4:0] CAUSE_RI  = 5'd10;
  localparam logic [4:0] CAUSE_OV  = 5'd12;

  typedef enum logic {
    S_IDLE,
    S_HANDLER
  } state_t;

  state_t          r_state;
  logic            r_redirect;
  logic            r_flush;
  logic [XLEN-1:0] r_redirect_pc;
  logic [XLEN-1:0] r_epc;
  logic [4:0]      r_cause;
  logic            r_in_handler;
  logic            r_dbl_fault;
  logic            w_irq_pend;
  logic            w_fault;
  logic            w_trap;
  logic [4:0]      w_cause;

`ifdef EXC_IRQ_EN
  logic r_irq_meta;
  logic r_irq_sync;

  // Two-flop synchroniser; the synced level itself is the pending interrupt
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_irq_meta <= 1'b0;
      r_irq_sync <= 1'b0;
    end else begin
      r_irq_meta <= exc.irq;
      r_irq_sync <= r_irq_meta;
    end
  end

  assign w_irq_pend = r_irq_sync;
`else
  assign w_irq_pend = 1'b0;
`endif

  assign w_fault = exc.excp | exc.ovf;
  assign w_trap  = exc.instr_valid & (w_fault | exc.eret | w_irq_pend);

  // Same-cycle priority: illegal > overflow > stray eret > interrupt
  always_comb begin
    w_cause = CAUSE_INT;
    if (exc.excp)      w_cause = CAUSE_RI;
    else if (exc.ovf)  w_cause = CAUSE_OV;
    else if (exc.eret) w_cause = CAUSE_RI;
  end

  // Sequencer: trap entry from IDLE, eret return and double-fault tracking from HANDLER
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_redirect    <= 1'b0;
      r_flush       <= 1'b0;
      r_redirect_pc <= '0;
      r_epc         <= '0;
      r_cause       <= '0;
      r_in_handler  <= 1'b0;
      r_dbl_fault   <= 1'b0;
    end else begin
      r_redirect <= 1'b0;
      r_flush    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_trap) begin
            r_epc         <= exc.instr_pc;
            r_cause       <= w_cause;
            r_redirect    <= 1'b1;
            r_flush       <= 1'b1;
            r_redirect_pc <= HANDLER_VEC;
            r_in_handler  <= 1'b1;
            r_state       <= S_HANDLER;
          end
        end
        S_HANDLER: begin
          if (exc.instr_valid && w_fault) begin
            r_dbl_fault <= 1'b1;
          end
          if (exc.instr_valid && exc.eret) begin
            r_redirect    <= 1'b1;
            r_flush       <= 1'b1;
            r_redirect_pc <= r_epc;
            r_in_handler  <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign exc.redirect    = r_redirect;
  assign exc.flush       = r_flush;
  assign exc.redirect_pc = r_redirect_pc;
  assign exc.epc         = r_epc;
  assign exc.cause       = r_cause;
  assign exc.in_handler  = r_in_handler;
  assign exc.dbl_fault   = r_dbl_fault;

endmodule
